gamma_lut_ctrl: RTL and testbench
=================================

// Module: gamma_lut_ctrl
// PURPOSE
//  Programmable gamma stage for the ISP colour pipe: 8-bit pixel in, 12-bit gamma-corrected pixel out.
//  Holds two 256-entry tables (active/shadow ping-pong). Host loads the shadow table; a commit request
//  swaps the tables only at the next frame start, so a frame never mixes curves.
//  After reset an init FSM fills bank 0 with a linear curve, so the pipe is usable before any host config.
// PARAMETERS
//  DIN_W   8    pixel/LUT address width (table depth = 2**DIN_W)
//  DOUT_W  12   pixel/LUT entry width
// PORTS
//  I_clk          in   1       pixel clock
//  I_rst_n        in   1       asynchronous active-low reset
//  I_vs           in   1       frame sync, active high; frame start = rising edge
//  I_pix_vld      in   1       input pixel valid
//  I_pix_data     in   DIN_W   input pixel
//  O_pix_vld      out  1       output pixel valid
//  O_pix_data     out  DOUT_W  gamma-corrected pixel
//  I_cfg_wr_en    in   1       host write strobe (shadow table); accepted only when O_cfg_ready=1
//  I_cfg_addr     in   DIN_W   shadow table index
//  I_cfg_data     in   DOUT_W  shadow table entry
//  I_cfg_commit   in   1       1-cycle pulse: request swap at next frame start
//  O_cfg_ready    out  1       1 when not in INIT
//  O_swap_pending out  1       commit seen, swap not yet done
//  O_active_bank  out  1       bank currently read by the pixel path
// BEHAVIOUR
//  Reset values: O_pix_vld=0, O_pix_data=0, O_cfg_ready=0, O_swap_pending=0, O_active_bank=0,
//   FSM=INIT, init counter=0. Table RAM contents are not reset.
//  FSM:
//   - INIT: write bank0[cnt] = {cnt, cnt[DIN_W-1 -: DOUT_W-DIN_W]}, i.e. (x<<4)|(x>>4) for defaults;
//     cnt++ each cycle. After the cnt=2**DIN_W-1 write (256 cycles) -> IDLE.
//   - IDLE: I_cfg_commit -> PEND.
//   - PEND: on a frame start, flip O_active_bank -> IDLE.
//  Commit and frame start in the same IDLE cycle: the swap happens in that cycle.
//  Commits while in PEND or INIT are ignored.
//  Frame-start detection: I_vs registered once; rise = I_vs & ~vs_d. The flip is registered on that
//   edge and applies to pixels entering from the next cycle on.
//  Pixel path, fixed latency 2:
//   - S0: register addr, vld and bank sel (bank sel = O_active_bank).
//   - S1: synchronous RAM read.
//   - S2: output register.
//   Each pixel completes with the bank sampled at S0. No backpressure; I_pix_vld is honoured every cycle.
//  During INIT the pixel path outputs the linear formula directly (bypass) with the same 2-cycle
//   latency, so output never depends on unwritten RAM.
//  Host writes always target bank ~O_active_bank, including while in PEND. The write address and
//   data are applied at the clock edge where the strobe is seen.
//  Writes with O_cfg_ready=0 are dropped.
//  O_pix_data holds its last value when O_pix_vld=0.
//  Reset asserted mid-frame or mid-INIT aborts everything. Pipeline valids clear and INIT restarts
//   from cnt=0 on reset release.
// STRUCTURE
//  Shared package isp_pkg:
//   - GAMMA_DIN_W, GAMMA_DOUT_W
//   - typedef gamma_state_t {INIT, IDLE, PEND}
//   - function linear_gamma(x)
//  Sub-module gamma_lut_bank: 1R1W simple dual-port RAM, depth 2**DIN_W, width DOUT_W, registered
//   read; instantiated twice. The controller muxes write ports (init vs host) and read-data select.
// TESTING
//  1. Reset release with I_pix_vld=1, data=0x80 held:
//     O_cfg_ready rises exactly 256 cycles after reset release; outputs 2 cycles later = 0x808.
//  2. After INIT, pixel 255 -> 4095; pixel 0 -> 0. Valid latency exactly 2; back-to-back pixels
//     give no bubbles.
//  3. Host writes shadow[i] = 4095-16*i, commits mid-frame: frame continues with the linear curve,
//     O_swap_pending=1. After the I_vs rise, pixel 0x10 -> 3839 and O_active_bank=1.
//  4. Commit in the same cycle as the I_vs rise: swap happens that cycle and O_swap_pending never
//     goes high. A second commit while in PEND does not cause a double swap.
//  5. Pixel sent the cycle before the bank flip returns the old-table value; the pixel sent the
//     cycle after returns the new-table value.
//  6. Assert I_rst_n low at cnt=100 in INIT and during an active frame: all outputs return to their
//     reset values; INIT restarts and completes 256 cycles after release; host writes during INIT
//     leave both banks unchanged.

Source files
------------

// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared ISP widths, gamma FSM states and the linear default curve
package isp_pkg;

    localparam int GAMMA_DIN_W  = 8;
    localparam int GAMMA_DOUT_W = 12;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        PEND
    } gamma_state_t;

    // Identity curve widened to DOUT_W by replicating the input MSBs into the low bits
    function automatic logic [GAMMA_DOUT_W-1:0] linear_gamma(input logic [GAMMA_DIN_W-1:0] x);
        return {x, x[GAMMA_DIN_W-1 -: GAMMA_DOUT_W-GAMMA_DIN_W]};
    endfunction

endpackage

// File: rtl/gamma_lut_bank.sv
// rtl/gamma_lut_bank.sv - 1R1W simple dual-port gamma table with registered read
module gamma_lut_bank #(
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [DIN_W-1:0]  wr_addr,
    input  logic [DOUT_W-1:0] wr_data,
    input  logic [DIN_W-1:0]  rd_addr,
    output logic [DOUT_W-1:0] rd_data
);

    logic [DOUT_W-1:0] mem [2**DIN_W];

    // Read-during-write to the same address returns the old entry
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/gamma_lut_ctrl.sv
// rtl/gamma_lut_ctrl.sv - ping-pong gamma LUT with frame-aligned table swap and linear init
module gamma_lut_ctrl
    import isp_pkg::*;
#(
    parameter int DIN_W  = GAMMA_DIN_W,
    parameter int DOUT_W = GAMMA_DOUT_W
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_vs,
    input  logic              I_pix_vld,
    input  logic [DIN_W-1:0]  I_pix_data,
    output logic              O_pix_vld,
    output logic [DOUT_W-1:0] O_pix_data,
    input  logic              I_cfg_wr_en,
    input  logic [DIN_W-1:0]  I_cfg_addr,
    input  logic [DOUT_W-1:0] I_cfg_data,
    input  logic              I_cfg_commit,
    output logic              O_cfg_ready,
    output logic              O_swap_pending,
    output logic              O_active_bank
);

    gamma_state_t      state, state_nxt;
    logic [DIN_W-1:0]  init_cnt;
    logic              vs_d;
    logic              frame_start;
    logic              flip;
    logic              in_init;
    logic              host_wr;

    logic              we0, we1;
    logic [DIN_W-1:0]  wa0;
    logic [DOUT_W-1:0] wd0;
    logic [DOUT_W-1:0] rd0, rd1;

    logic              s0_vld, s0_bank, s0_byp;
    logic [DIN_W-1:0]  s0_addr;
    logic              s1_vld, s1_bank, s1_byp;
    logic [DIN_W-1:0]  s1_addr;

    assign frame_start    = I_vs & ~vs_d;
    assign in_init        = (state == INIT);
    assign O_cfg_ready    = ~in_init;
    assign O_swap_pending = (state == PEND);
    assign host_wr        = I_cfg_wr_en & ~in_init;

    always_comb begin
        state_nxt = state;
        flip      = 1'b0;
        case (state)
            INIT: if (init_cnt == '1) state_nxt = IDLE;
            IDLE: begin
                // A commit landing on the frame start swaps immediately, no PEND detour
                if (I_cfg_commit) begin
                    if (frame_start) flip = 1'b1;
                    else             state_nxt = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    flip      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            vs_d          <= 1'b0;
            O_active_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_d  <= I_vs;
            if (in_init) init_cnt <= init_cnt + 1'b1;
            if (flip)    O_active_bank <= ~O_active_bank;
        end
    end

    // Init owns bank 0; host always writes the bank the pixel path is not reading
    assign we0 = in_init | (host_wr & O_active_bank);
    assign wa0 = in_init ? init_cnt : I_cfg_addr;
    assign wd0 = in_init ? linear_gamma(init_cnt) : I_cfg_data;
    assign we1 = host_wr & ~O_active_bank;

    gamma_lut_bank #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) u_bank0 (
        .clk     (I_clk),
        .wr_en   (we0),
        .wr_addr (wa0),
        .wr_data (wd0),
        .rd_addr (s0_addr),
        .rd_data (rd0)
    );

    gamma_lut_bank #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) u_bank1 (
        .clk     (I_clk),
        .wr_en   (we1),
        .wr_addr (I_cfg_addr),
        .wr_data (I_cfg_data),
        .rd_addr (s0_addr),
        .rd_data (rd1)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s0_vld     <= 1'b0;
            s0_bank    <= 1'b0;
            s0_byp     <= 1'b0;
            s0_addr    <= '0;
            s1_vld     <= 1'b0;
            s1_bank    <= 1'b0;
            s1_byp     <= 1'b0;
            s1_addr    <= '0;
            O_pix_vld  <= 1'b0;
            O_pix_data <= '0;
        end else begin
            s0_vld    <= I_pix_vld;
            s0_bank   <= O_active_bank;
            s0_byp    <= in_init;
            s0_addr   <= I_pix_data;
            s1_vld    <= s0_vld;
            s1_bank   <= s0_bank;
            s1_byp    <= s0_byp;
            s1_addr   <= s0_addr;
            O_pix_vld <= s1_vld;
            if (s1_vld) begin
                O_pix_data <= s1_byp ? linear_gamma(s1_addr) : (s1_bank ? rd1 : rd0);
            end
        end
    end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// tb/tb_gamma_lut_ctrl.sv - randomized directed bench for gamma_lut_ctrl against a table model
module tb_gamma_lut_ctrl;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b1;
    logic        I_vs = 1'b0;
    logic        I_pix_vld = 1'b0;
    logic [7:0]  I_pix_data = '0;
    logic        O_pix_vld;
    logic [11:0] O_pix_data;
    logic        I_cfg_wr_en = 1'b0;
    logic [7:0]  I_cfg_addr = '0;
    logic [11:0] I_cfg_data = '0;
    logic        I_cfg_commit = 1'b0;
    logic        O_cfg_ready;
    logic        O_swap_pending;
    logic        O_active_bank;

    gamma_lut_ctrl dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_vs           (I_vs),
        .I_pix_vld      (I_pix_vld),
        .I_pix_data     (I_pix_data),
        .O_pix_vld      (O_pix_vld),
        .O_pix_data     (O_pix_data),
        .I_cfg_wr_en    (I_cfg_wr_en),
        .I_cfg_addr     (I_cfg_addr),
        .I_cfg_data     (I_cfg_data),
        .I_cfg_commit   (I_cfg_commit),
        .O_cfg_ready    (O_cfg_ready),
        .O_swap_pending (O_swap_pending),
        .O_active_bank  (O_active_bank)
    );

    always #5 I_clk = ~I_clk;

    int          tests = 0;
    int          fails = 0;

    logic [11:0] m_bank [2][256];
    int          init_left;
    int          active;
    bit          pending;
    bit          vs_prev;
    bit          h_vld [2];
    logic [11:0] h_dat [2];
    bit          e_vld;
    logic [11:0] e_dat;

    function automatic logic [11:0] lin(input int x);
        return 12'((x * 16) + (x / 16));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, then check every output
    task automatic cyc(input bit vld, input int px, input bit vs, input bit cm,
                       input bit wr, input int wa, input int wd);
        bit          in_init;
        bit          rise;
        logic [11:0] pv;
        I_pix_vld    = vld;
        I_pix_data   = 8'(px);
        I_vs         = vs;
        I_cfg_commit = cm;
        I_cfg_wr_en  = wr;
        I_cfg_addr   = 8'(wa);
        I_cfg_data   = 12'(wd);
        in_init = (init_left > 0);
        pv = in_init ? lin(px & 255) : m_bank[active][px & 255];
        e_vld = h_vld[1];
        if (h_vld[1]) e_dat = h_dat[1];
        h_vld[1] = h_vld[0];
        h_dat[1] = h_dat[0];
        h_vld[0] = vld;
        h_dat[0] = pv;
        if (wr && !in_init) m_bank[1 - active][wa & 255] = 12'(wd);
        rise    = vs && !vs_prev;
        vs_prev = vs;
        if (in_init) begin
            init_left--;
        end else if (pending) begin
            if (rise) begin
                active  = 1 - active;
                pending = 1'b0;
            end
        end else if (cm) begin
            if (rise) active = 1 - active;
            else      pending = 1'b1;
        end
        @(posedge I_clk);
        #1;
        chk("pix_vld", 32'(O_pix_vld), 32'(e_vld));
        chk("pix_data", 32'(O_pix_data), 32'(e_dat));
        chk("cfg_ready", 32'(O_cfg_ready), 32'(init_left == 0));
        chk("swap_pending", 32'(O_swap_pending), 32'(pending));
        chk("active_bank", 32'(O_active_bank), 32'(active));
    endtask

    task automatic pix(input bit vld, input int px, input bit vs);
        cyc(vld, px, vs, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        #2 I_rst_n = 1'b0;
        #1;
        chk("rst_pix_vld", 32'(O_pix_vld), 0);
        chk("rst_pix_data", 32'(O_pix_data), 0);
        chk("rst_cfg_ready", 32'(O_cfg_ready), 0);
        chk("rst_swap_pending", 32'(O_swap_pending), 0);
        chk("rst_active_bank", 32'(O_active_bank), 0);
        repeat (n) @(posedge I_clk);
        #1;
        chk("rst_hold_vld", 32'(O_pix_vld), 0);
        chk("rst_hold_ready", 32'(O_cfg_ready), 0);
        init_left = 256;
        active    = 0;
        pending   = 1'b0;
        vs_prev   = 1'b0;
        h_vld     = '{1'b0, 1'b0};
        e_vld     = 1'b0;
        e_dat     = '0;
        for (int i = 0; i < 256; i++) m_bank[0][i] = lin(i);
        I_rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int a;

        // Reset release with 0x80 streaming; ready after exactly 256 INIT cycles
        do_reset(3);
        cnt = 0;
        while (!O_cfg_ready && cnt < 400) begin
            pix(1'b1, 8'h80, 1'b0);
            cnt++;
        end
        chk("init_cycles", 32'(cnt), 256);
        pix(1'b1, 8'h80, 1'b0);
        pix(1'b1, 8'h80, 1'b0);
        chk("init_out_808", 32'(O_pix_data), 32'h808);

        // Table extremes, then a random stream with gaps
        pix(1'b1, 255, 1'b0);
        pix(1'b1, 0, 1'b0);
        pix(1'b0, 0, 1'b0);
        chk("pix_255", 32'(O_pix_data), 4095);
        pix(1'b0, 0, 1'b0);
        chk("pix_0", 32'(O_pix_data), 0);
        for (int i = 0; i < 40; i++) pix(1'(($urandom % 4) != 0), int'($urandom % 256), 1'b0);

        // Frame in progress; load shadow curve and commit mid-frame
        pix(1'b1, int'($urandom % 256), 1'b1);
        for (int i = 0; i < 256; i++)
            cyc(1'($urandom % 2), int'($urandom % 256), 1'b1, 1'(i == 128), 1'b1, i, 4095 - 16 * i);
        chk("commit_pending", 32'(O_swap_pending), 1);
        for (int i = 0; i < 3; i++) pix(1'b1, int'($urandom % 256), 1'b0);
        pix(1'b1, int'($urandom % 256), 1'b1);
        pix(1'b1, 8'h10, 1'b1);
        pix(1'b0, 0, 1'b1);
        pix(1'b0, 0, 1'b1);
        chk("swap_pix_10", 32'(O_pix_data), 3839);
        chk("swap_bank1", 32'(O_active_bank), 1);

        // Random curve into bank 0, then commit exactly on the frame start with pixels flowing
        for (int i = 0; i < 256; i++)
            cyc(1'b1, int'($urandom % 256), 1'b1, 1'b0, 1'b1, i, int'($urandom % 4096));
        pix(1'b1, int'($urandom % 256), 1'b0);
        cyc(1'b1, int'($urandom % 256), 1'b1, 1'b1, 1'b0, 0, 0);
        chk("same_cycle_bank0", 32'(O_active_bank), 0);
        for (int i = 0; i < 4; i++) pix(1'b1, int'($urandom % 256), 1'b1);

        // Commit, repeat commit while pending, single swap at the next rise only
        cyc(1'b1, int'($urandom % 256), 1'b0, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, int'($urandom % 256), 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) pix(1'b1, int'($urandom % 256), 1'b0);
        for (int i = 0; i < 4; i++) pix(1'b1, int'($urandom % 256), 1'b1);
        chk("single_swap", 32'(O_active_bank), 1);
        pix(1'b1, int'($urandom % 256), 1'b0);
        for (int i = 0; i < 4; i++) pix(1'b1, int'($urandom % 256), 1'b1);

        // Reset in an active frame, again at INIT cnt=100, with host writes during INIT
        for (int i = 0; i < 5; i++) pix(1'b1, int'($urandom % 256), 1'b1);
        do_reset(2);
        for (int i = 0; i < 100; i++)
            cyc(1'b1, int'($urandom % 256), 1'b1, 1'b0, 1'b1, int'($urandom % 256), int'($urandom % 4096));
        do_reset(2);
        cnt = 0;
        while (!O_cfg_ready && cnt < 400) begin
            a = int'($urandom % 256);
            cyc(1'b1, a, 1'b0, 1'b1, 1'b1, a, int'($urandom % 4096));
            cnt++;
        end
        chk("reinit_cycles", 32'(cnt), 256);
        for (int i = 0; i < 20; i++) pix(1'b1, int'($urandom % 256), 1'b0);
        cyc(1'b1, int'($urandom % 256), 1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 256; i++) pix(1'b1, i, 1'b1);
        pix(1'b0, 0, 1'b1);
        pix(1'b0, 0, 1'b1);
        chk("bank1_kept_255", 32'(O_pix_data), 32'(m_bank[1][255]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
